// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/LS memory port arbiter.
// Imported by the interface, the picker and the top-level arbiter.
package mem_arb_pkg;

   // Arbiter FSM: idle, waiting on memory read latency, one-cycle response.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_WAIT = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   // Which requester owns the current transaction.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   localparam int MEM_LAT_DEF = 2;
   localparam int AW_DEF      = 32;
   localparam int DW_DEF      = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the LSU, the arbiter and the unified
// memory. The arbiter uses the slave modport; the environment uses master.
//
// Handshake: a requester raises *_req with its fields and holds them stable
// until it sees *_gnt high in the same cycle; that cycle is the issue cycle
// and the only cycle the fields are sampled. Dropping req before gnt
// cancels the request. Each grant yields exactly one single-cycle *_rvalid
// pulse later (load data, or store acknowledge with rdata 0).
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   import mem_arb_pkg::*;

   // fetch requester
   logic            i_if_req;
   logic [AW-1:0]   i_if_addr;
   logic            o_if_gnt;
   logic            o_if_rvalid;
   logic [DW-1:0]   o_if_rdata;

   // load/store requester
   logic            i_ls_req;
   logic            i_ls_we;
   logic [AW-1:0]   i_ls_addr;
   logic [DW-1:0]   i_ls_wdata;
   logic [DW/8-1:0] i_ls_bmask;
   logic            o_ls_gnt;
   logic            o_ls_rvalid;
   logic [DW-1:0]   o_ls_rdata;

   // memory side
   logic            o_mem_req;
   logic            o_mem_we;
   logic [AW-1:0]   o_mem_addr;
   logic [DW-1:0]   o_mem_wdata;
   logic [DW/8-1:0] o_mem_bmask;
   logic [DW-1:0]   i_mem_rdata;

   // status / debug
   logic            o_busy;
   arb_state_e      o_dbg_state;

   modport slave (
      input  i_if_req, i_if_addr,
      input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_bmask,
      input  i_mem_rdata,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
      output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
      output o_busy, o_dbg_state
   );

   modport master (
      output i_if_req, i_if_addr,
      output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_bmask,
      output i_mem_rdata,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
      input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
      input  o_busy, o_dbg_state
   );

endinterface

// File: rtl/arb_pick.sv
// Two-way requester picker for the memory port arbiter.
// Macro ARB_RR_EN: when defined, ties go to the requester that did not win
// the previous grant; when undefined, LS always beats IF.
// The output is only meaningful when at least one request is high.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic   i_req_if,
   input  logic   i_req_ls,
   input  owner_e i_last_winner,
   output owner_e o_pick
);

`ifdef ARB_RR_EN
   // Round-robin on a tie; a lone requester always wins.
   always_comb begin
      o_pick = OWN_IF;
      if (i_req_if && i_req_ls) begin
         o_pick = (i_last_winner == OWN_LS) ? OWN_IF : OWN_LS;
      end else if (i_req_ls) begin
         o_pick = OWN_LS;
      end
   end
`else
   // Fixed priority: the LS request belongs to the older instruction.
   logic w_unused_pick_in;
   assign w_unused_pick_in = i_req_if ^ (i_last_winner == OWN_LS);

   // LS wins whenever it asks; otherwise IF.
   always_comb begin
      o_pick = i_req_ls ? OWN_LS : OWN_IF;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and
// load/store (LS). One command outstanding at a time; loads wait a fixed
// MEM_LAT cycles for read data, stores are acknowledged the next cycle.
// Macro ARB_RR_EN: round-robin tie-breaking with a last-winner register
// (resets to LS so the first tie goes to IF); default is fixed LS > IF.
// MEM_LAT legal range is 1..15.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic                i_clk,
   input  logic                i_reset,
   mem_port_arbiter_if.slave   io_bus
);

   localparam int             CW       = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(MEM_LAT - 1);

   arb_state_e      r_state;
   arb_state_e      w_next_state;
   owner_e          r_owner;
   owner_e          w_pick;
   owner_e          w_last_winner;
   logic [CW-1:0]   r_cnt;
   logic [DW-1:0]   r_if_rdata;
   logic [DW-1:0]   r_ls_rdata;

   logic            w_arb_en;
   logic            w_gnt_if;
   logic            w_gnt_ls;
   logic            w_gnt_any;
   logic            w_is_store;
   logic            w_cnt_zero;
   logic            w_capture;
   logic [AW-1:0]   w_if_addr;
   logic [AW-1:0]   w_ls_addr;

   assign w_if_addr = io_bus.i_if_addr;
   assign w_ls_addr = io_bus.i_ls_addr;

   // Arbitration happens only in IDLE and RESP; grants are suppressed while
   // reset is asserted so nothing is issued into a core being reset.
   assign w_arb_en   = !i_reset && ((r_state == ARB_IDLE) || (r_state == ARB_RESP));
   assign w_gnt_ls   = w_arb_en && io_bus.i_ls_req && (w_pick == OWN_LS);
   assign w_gnt_if   = w_arb_en && io_bus.i_if_req && (w_pick == OWN_IF);
   assign w_gnt_any  = w_gnt_if || w_gnt_ls;
   assign w_is_store = w_gnt_ls && io_bus.i_ls_we;
   assign w_cnt_zero = (r_cnt == '0);
   assign w_capture  = (r_state == ARB_WAIT) && w_cnt_zero;

`ifdef ARB_RR_EN
   owner_e r_last_winner;

   // Remember who won the most recent grant for round-robin tie-breaking.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_last_winner <= OWN_LS;
      end else if (w_gnt_any) begin
         r_last_winner <= w_pick;
      end
   end

   assign w_last_winner = r_last_winner;
`else
   assign w_last_winner = OWN_LS;
`endif

   arb_pick u_pick (
      .i_req_if      (io_bus.i_if_req),
      .i_req_ls      (io_bus.i_ls_req),
      .i_last_winner (w_last_winner),
      .o_pick        (w_pick)
   );

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next state: loads wait out the latency, stores respond immediately.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ARB_IDLE, ARB_RESP: begin
            if (w_gnt_any) begin
               w_next_state = w_is_store ? ARB_RESP : ARB_WAIT;
            end else begin
               w_next_state = ARB_IDLE;
            end
         end
         ARB_WAIT: begin
            if (w_cnt_zero) begin
               w_next_state = ARB_RESP;
            end
         end
         default: w_next_state = ARB_IDLE;
      endcase
   end

   // Latency counter and owner: loaded on issue, counter runs down in WAIT.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt   <= '0;
         r_owner <= OWN_IF;
      end else begin
         if (w_gnt_any) begin
            r_owner <= w_pick;
         end
         if (w_gnt_any && !w_is_store) begin
            r_cnt <= CNT_LOAD;
         end else if ((r_state == ARB_WAIT) && !w_cnt_zero) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   // Read data registers: capture memory data for the owner at the end of
   // WAIT; a store clears LS data so its acknowledge carries 0.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_if_rdata <= '0;
         r_ls_rdata <= '0;
      end else if (w_capture) begin
         if (r_owner == OWN_IF) begin
            r_if_rdata <= io_bus.i_mem_rdata;
         end else begin
            r_ls_rdata <= io_bus.i_mem_rdata;
         end
      end else if (w_is_store) begin
         r_ls_rdata <= '0;
      end
   end

   // FSM outputs: grants and memory command follow the winner combinationally;
   // the owner's rvalid pulses for the single RESP cycle.
   always_comb begin
      io_bus.o_if_gnt    = w_gnt_if;
      io_bus.o_ls_gnt    = w_gnt_ls;
      io_bus.o_mem_req   = 1'b0;
      io_bus.o_mem_we    = 1'b0;
      io_bus.o_mem_addr  = '0;
      io_bus.o_mem_wdata = '0;
      io_bus.o_mem_bmask = '0;
      if (w_gnt_ls) begin
         io_bus.o_mem_req   = 1'b1;
         io_bus.o_mem_we    = io_bus.i_ls_we;
         io_bus.o_mem_addr  = w_ls_addr;
         io_bus.o_mem_wdata = io_bus.i_ls_wdata;
         io_bus.o_mem_bmask = io_bus.i_ls_bmask;
      end else if (w_gnt_if) begin
         io_bus.o_mem_req   = 1'b1;
         io_bus.o_mem_addr  = w_if_addr;
         io_bus.o_mem_bmask = '1;
      end
      io_bus.o_if_rvalid = (r_state == ARB_RESP) && (r_owner == OWN_IF);
      io_bus.o_ls_rvalid = (r_state == ARB_RESP) && (r_owner == OWN_LS);
      io_bus.o_busy      = (r_state != ARB_IDLE);
      io_bus.o_dbg_state = r_state;
   end

   assign io_bus.o_if_rdata = r_if_rdata;
   assign io_bus.o_ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Instance A uses MEM_LAT=2 and a
// small byte-maskable memory model; instance B uses MEM_LAT=1 for the
// back-to-back fetch stream. Expected responses go into queues at grant
// time and are popped by monitors whenever an rvalid pulse appears.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LAT_A = 2;
   localparam int LAT_B = 1;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   exp_t a_if_q[$];
   exp_t a_ls_q[$];
   exp_t b_q[$];

   logic [DW-1:0] mem [logic [AW-1:0]];
   int            a_due = -1;
   logic [AW-1:0] a_addr = '0;
   int            b_due = -1;
   logic [AW-1:0] b_addr = '0;
   logic          b_prev_rv = 1'b0;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_A)) u_dut_a (
      .i_clk   (clk),
      .i_reset (rst),
      .io_bus  (bus_a)
   );

   mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_B)) u_dut_b (
      .i_clk   (clk),
      .i_reset (rst),
      .io_bus  (bus_b)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void flag(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event seen, required none (cycle %0d)", name, cyc);
   endfunction

   // memory model A: stores update bytes, loads answer LAT_A cycles after issue
   always @(negedge clk) begin : mem_a
      logic [DW-1:0] w;
      if (bus_a.o_mem_req) begin
         if (bus_a.o_mem_we) begin
            w = mem.exists(bus_a.o_mem_addr) ? mem[bus_a.o_mem_addr] : '0;
            for (int i = 0; i < DW/8; i++) begin
               if (bus_a.o_mem_bmask[i]) w[8*i +: 8] = bus_a.o_mem_wdata[8*i +: 8];
            end
            mem[bus_a.o_mem_addr] = w;
         end else begin
            a_due  = cyc + LAT_A;
            a_addr = bus_a.o_mem_addr;
         end
      end
      if (cyc == a_due) bus_a.i_mem_rdata = mem.exists(a_addr) ? mem[a_addr] : '0;
      else              bus_a.i_mem_rdata = 32'hBAD0_0000 | 32'(cyc);
   end

   // memory model B: read data = address + 0x1000_0000, LAT_B cycles after issue
   always @(negedge clk) begin : mem_b
      if (bus_b.o_mem_req && !bus_b.o_mem_we) begin
         b_due  = cyc + LAT_B;
         b_addr = bus_b.o_mem_addr;
      end
      if (cyc == b_due) bus_b.i_mem_rdata = b_addr + 32'h1000_0000;
      else              bus_b.i_mem_rdata = 32'hBAD0_0000 | 32'(cyc);
   end

   // scoreboard monitor A
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (bus_a.o_if_rvalid && bus_a.o_ls_rvalid) flag("a_both_rvalid");
      if (bus_a.o_if_rvalid) begin
         if (a_if_q.size() == 0) flag("a_if_rvalid_unexpected");
         else begin
            e = a_if_q.pop_front();
            chk("a_if_rdata", bus_a.o_if_rdata, e.data);
            chk("a_if_rvalid_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (bus_a.o_ls_rvalid) begin
         if (a_ls_q.size() == 0) flag("a_ls_rvalid_unexpected");
         else begin
            e = a_ls_q.pop_front();
            chk("a_ls_rdata", bus_a.o_ls_rdata, e.data);
            chk("a_ls_rvalid_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (!rst && (bus_a.o_mem_req !== (bus_a.o_if_gnt | bus_a.o_ls_gnt))) flag("a_mem_req_vs_gnt");
   end

   // scoreboard monitor B
   always @(negedge clk) begin : mon_b
      exp_t e;
      if (bus_b.o_ls_rvalid) flag("b_ls_rvalid_unexpected");
      if (bus_b.o_if_rvalid) begin
         if (b_prev_rv) flag("b_rvalid_adjacent");
         if (b_q.size() == 0) flag("b_if_rvalid_unexpected");
         else begin
            e = b_q.pop_front();
            chk("b_if_rdata", bus_b.o_if_rdata, e.data);
            chk("b_if_rvalid_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      b_prev_rv = bus_b.o_if_rvalid;
   end

   // driver A: raise a request, hold until granted, check the issue-cycle
   // command, push the expected response, drop the request next cycle
   task automatic do_req(input bit is_ls, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [3:0] bmask,
                         input logic [DW-1:0] exp_data, input bit push, output int gcyc);
      bit   got = 1'b0;
      exp_t e;
      gcyc = -1;
      if (is_ls) begin
         bus_a.i_ls_req   = 1'b1;
         bus_a.i_ls_we    = we;
         bus_a.i_ls_addr  = addr;
         bus_a.i_ls_wdata = wdata;
         bus_a.i_ls_bmask = bmask;
      end else begin
         bus_a.i_if_req  = 1'b1;
         bus_a.i_if_addr = addr;
      end
      for (int t = 0; t < 40 && !got; t++) begin
         @(negedge clk);
         if (is_ls ? bus_a.o_ls_gnt : bus_a.o_if_gnt) begin
            got  = 1'b1;
            gcyc = cyc;
            chk("mem_addr_issue", bus_a.o_mem_addr, addr);
            chk("mem_req_issue", 32'(bus_a.o_mem_req), 32'd1);
            chk("mem_we_issue", 32'(bus_a.o_mem_we), 32'(we));
            if (we) begin
               chk("mem_wdata_issue", bus_a.o_mem_wdata, wdata);
               chk("mem_bmask_issue", 32'(bus_a.o_mem_bmask), 32'(bmask));
            end
            if (push) begin
               e.data = we ? '0 : exp_data;
               e.cyc  = cyc + (we ? 1 : LAT_A + 1);
               if (is_ls) a_ls_q.push_back(e);
               else       a_if_q.push_back(e);
            end
         end
      end
      if (!got) flag(is_ls ? "ls_gnt_timeout" : "if_gnt_timeout");
      @(posedge clk); #1;
      if (is_ls) begin
         bus_a.i_ls_req   = 1'b0;
         bus_a.i_ls_we    = 1'b0;
         bus_a.i_ls_addr  = '0;
         bus_a.i_ls_wdata = '0;
         bus_a.i_ls_bmask = '0;
      end else begin
         bus_a.i_if_req  = 1'b0;
         bus_a.i_if_addr = '0;
      end
   endtask

   // wait until instance A has no outstanding expectations and is idle
   task automatic drain_a();
      bit done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         done = (a_if_q.size() == 0) && (a_ls_q.size() == 0) && !bus_a.o_busy;
      end
      if (!done) flag("a_drain_timeout");
      @(posedge clk); #1;
   endtask

   // driver B: IF held high for four consecutive fetches
   task automatic run_b2b();
      int   gb[4];
      int   k = 0;
      bit   done = 1'b0;
      exp_t e;
      bus_b.i_if_addr = 32'h0000_0200;
      bus_b.i_if_req  = 1'b1;
      for (int t = 0; t < 40 && k < 4; t++) begin
         @(negedge clk);
         if (bus_b.o_if_gnt) begin
            gb[k] = cyc;
            chk("b_mem_addr_issue", bus_b.o_mem_addr, 32'h0000_0200 + 32'(4*k));
            e.data = 32'h1000_0200 + 32'(4*k);
            e.cyc  = cyc + LAT_B + 1;
            b_q.push_back(e);
            k++;
            @(posedge clk); #1;
            if (k < 4) bus_b.i_if_addr = 32'h0000_0200 + 32'(4*k);
            else       bus_b.i_if_req  = 1'b0;
         end
      end
      bus_b.i_if_req = 1'b0;
      chk("b_grant_count", 32'(k), 32'd4);
      for (int i = 1; i < k; i++) chk("b_gnt_spacing", 32'(gb[i] - gb[i-1]), 32'd2);
      for (int t = 0; t < 20 && !done; t++) begin
         @(negedge clk);
         done = (b_q.size() == 0) && !bus_b.o_busy;
      end
      if (!done) flag("b_drain_timeout");
   endtask

   task automatic check_reset_outputs();
      chk("rst_if_gnt", 32'(bus_a.o_if_gnt), 32'd0);
      chk("rst_ls_gnt", 32'(bus_a.o_ls_gnt), 32'd0);
      chk("rst_mem_req", 32'(bus_a.o_mem_req), 32'd0);
      chk("rst_mem_we", 32'(bus_a.o_mem_we), 32'd0);
      chk("rst_if_rvalid", 32'(bus_a.o_if_rvalid), 32'd0);
      chk("rst_ls_rvalid", 32'(bus_a.o_ls_rvalid), 32'd0);
      chk("rst_if_rdata", bus_a.o_if_rdata, 32'd0);
      chk("rst_ls_rdata", bus_a.o_ls_rdata, 32'd0);
      chk("rst_busy", 32'(bus_a.o_busy), 32'd0);
      chk("rst_state", 32'(bus_a.o_dbg_state), 32'(ARB_IDLE));
   endtask

   // main directed sequence
   initial begin
      int g;
      int g_if;
      int g_ls;
      rst = 1'b1;
      bus_a.i_if_req = 1'b0; bus_a.i_if_addr = '0;
      bus_a.i_ls_req = 1'b0; bus_a.i_ls_we = 1'b0; bus_a.i_ls_addr = '0;
      bus_a.i_ls_wdata = '0; bus_a.i_ls_bmask = '0;
      bus_b.i_if_req = 1'b0; bus_b.i_if_addr = '0;
      bus_b.i_ls_req = 1'b0; bus_b.i_ls_we = 1'b0; bus_b.i_ls_addr = '0;
      bus_b.i_ls_wdata = '0; bus_b.i_ls_bmask = '0;
      mem[32'h0000_0040] = 32'h0050_0093;
      mem[32'h0000_0044] = 32'h0000_0013;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // single fetch: gnt cycle 0, rvalid cycle 3, busy cycles 1..3
      do_req(1'b0, 1'b0, 32'h0000_0040, '0, 4'h0, 32'h0050_0093, 1'b1, g);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("fetch_busy", 32'(bus_a.o_busy), (k <= 3) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      drain_a();

      // reset in WAIT: transaction discarded, grants blocked during reset
      do_req(1'b0, 1'b0, 32'h0000_0044, '0, 4'h0, 32'h0000_0013, 1'b0, g);
      rst = 1'b1;
      bus_a.i_if_req  = 1'b1;
      bus_a.i_if_addr = 32'h0000_0044;
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;
      bus_a.i_if_req  = 1'b0;
      bus_a.i_if_addr = '0;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("post_reset_state", 32'(bus_a.o_dbg_state), 32'(ARB_IDLE));
      @(posedge clk); #1;

      // store ack: we=1 in issue cycle, ack with rdata 0 next cycle
      do_req(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, '0, 1'b1, g);
      drain_a();

      // contention: both load in the same cycle
      fork
         do_req(1'b0, 1'b0, 32'h0000_0044, '0, 4'h0, 32'h0000_0013, 1'b1, g_if);
         do_req(1'b1, 1'b0, 32'h0000_0100, '0, 4'h0, 32'hDEAD_BEEF, 1'b1, g_ls);
      join
`ifdef ARB_RR_EN
      chk("contention_second_gnt", 32'(g_ls - g_if), 32'd3);
`else
      chk("contention_second_gnt", 32'(g_if - g_ls), 32'd3);
`endif
      drain_a();

      // IF request raised during WAIT and dropped before RESP: no transaction
      fork
         do_req(1'b1, 1'b0, 32'h0000_0040, '0, 4'h0, 32'h0050_0093, 1'b1, g);
         begin
            @(posedge clk); #1;
            bus_a.i_if_req  = 1'b1;
            bus_a.i_if_addr = 32'h0000_0080;
            @(negedge clk);
            chk("if_gnt_during_wait", 32'(bus_a.o_if_gnt), 32'd0);
            @(posedge clk); #1;
            bus_a.i_if_req  = 1'b0;
            bus_a.i_if_addr = '0;
         end
      join
      drain_a();

      // partial store then load back: 0xDEADBEEF with bytes 0,2 <- 0x11223344
      do_req(1'b1, 1'b1, 32'h0000_0100, 32'h1122_3344, 4'b0101, '0, 1'b1, g);
      drain_a();
      do_req(1'b1, 1'b0, 32'h0000_0100, '0, 4'h0, 32'hDE22_BE44, 1'b1, g);
      drain_a();

      // back-to-back fetches on the MEM_LAT=1 instance
      run_b2b();

      repeat (4) @(negedge clk);
      chk("a_if_q_left", 32'(a_if_q.size()), 32'd0);
      chk("a_ls_q_left", 32'(a_ls_q.size()), 32'd0);
      chk("b_q_left", 32'(b_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
